mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one backing-memory port between the instruction-fetch path and the data cacheline (loads, stores, refills). Serialises requests, one outstanding transaction at a time, and drives a request/grant/response handshake on both sides. Recovers from a stalled memory with a timeout counter that returns an error response to the owning requester. Sits between the core-side cache/fetch logic and the memory model or bus bridge.

## Interface
- WIDTH, 32, address and data width
- TIMEOUT_CYCLES, 64, cycles allowed in REQ+WAIT before an error response; 0 disables the timeout
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- i_req_i  in  1  fetch request; held with i_addr_i until i_gnt_o
- i_addr_i  in  WIDTH  fetch address
- i_gnt_o  out  1  fetch request accepted (one-cycle pulse)
- i_rvalid_o  out  1  fetch response valid (one-cycle pulse)
- i_rdata_o  out  WIDTH  fetch response data
- i_err_o  out  1  fetch response is a timeout error; qualified by i_rvalid_o
- d_req_i  in  1  data request; held with d_* fields until d_gnt_o
- d_we_i  in  1  store when 1, load/refill when 0
- d_byte_op_i  in  1  byte access
- d_addr_i  in  WIDTH  data address
- d_wdata_i  in  WIDTH  store data
- d_gnt_o, d_rvalid_o, d_rdata_o (WIDTH), d_err_o  out  as the fetch side
- mem_req_o  out  1  memory request, held until mem_gnt_i
- mem_we_o, mem_byte_op_o  out  1  latched owner fields; 0 for fetch
- mem_addr_o, mem_wdata_o  out  WIDTH  latched owner fields; mem_wdata_o is 0 for fetch
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response; stores also get one, as acknowledge
- mem_rdata_i  in  WIDTH  memory read data
- busy_o  out  1  state is not IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any request is present, pick an owner, assert that owner's gnt_o combinationally in the same cycle, latch its fields and owner id, and go to REQ. The other gnt_o stays 0.
- REQ: mem_req_o=1 with latched fields. On mem_gnt_i, go to WAIT. mem_rvalid_i is ignored in REQ.
- WAIT: on mem_rvalid_i, register mem_rdata_i, clear err and go to RESP.
- RESP: the owner's rvalid_o=1 for exactly one cycle, with rdata_o and err_o registered. Non-owner rvalid_o=0. Next state is IDLE. No grant is issued in RESP.
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ/WAIT. If it reaches TIMEOUT_CYCLES-1 with no advancing event, go to RESP with err=1 and rdata=0, and drop mem_req_o.
- A mem_rvalid_i in IDLE or RESP is ignored.
- Default priority: data wins over fetch when both request in IDLE.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values: all gnt/rvalid/err outputs 0, rdata outputs 0, mem_req_o 0, mem_* fields 0, busy_o 0, state IDLE, counter 0, last owner = fetch.
- Sequence: request and gnt at cycle 0 → mem_req_o from cycle 1 → mem_gnt_i at cycle g → WAIT from g+1 → mem_rvalid_i at cycle r → owner rvalid_o at r+1 → IDLE at r+2.
- Minimum latency from gnt to rvalid is 3 cycles (g=1, r=2). Maximum throughput is one transaction per 4 cycles.
- Fields on mem_* stay stable from REQ entry until RESP and do not track requester inputs.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values. The memory transaction is not cancelled, and a late response is ignored by the IDLE rule.

## Configuration
- RR_FAIRNESS_EN defined: a two-way round-robin arbiter is compiled in. On a conflict, grant the requester not served last. The last-owner register resets to fetch, so the first conflict goes to data. A lone requester is always granted.
- RR_FAIRNESS_EN undefined: fixed data-over-fetch priority and no last-owner register.

## Structure
- Package mem_arb_pkg holds:
  - owner_e (OWNER_I, OWNER_D)
  - state_e (IDLE, REQ, WAIT, RESP)
  - default WIDTH/TIMEOUT_CYCLES localparams
- Sub-module mem_arb_select: combinational owner choice from the two requests plus, under RR_FAIRNESS_EN, the last owner. It keeps the `ifdef out of the FSM.

## Test plan
- Fetch only, i_addr_i=0x40, memory grants at cycle 1 and returns 0xDEADBEEF at cycle 2 → i_gnt_o at cycle 0, i_rvalid_o at cycle 3 with 0xDEADBEEF, i_err_o=0, mem_we_o=0.
- d_req_i and i_req_i both held high for 3 transactions → without RR_FAIRNESS_EN the grants are D,D,D. With RR_FAIRNESS_EN the grants are D,I,D.
- Store d_addr_i=0x104, d_wdata_i=0x000000AB, d_byte_op_i=1 → mem_we_o=1, mem_byte_op_o=1, mem_wdata_o=0xAB held until mem_gnt_i. d_rvalid_o pulses the cycle after the ack.
- TIMEOUT_CYCLES=8, mem_gnt_i never asserted → mem_req_o high 8 cycles then low. d_rvalid_o=1, d_err_o=1, d_rdata_o=0. busy_o returns to 0.
- rst_ni pulsed low while in WAIT, mem_rvalid_i arriving 2 cycles later → no rvalid on either side. Next request is served normally.
- Memory delays mem_gnt_i 5 cycles and mem_rvalid_i 4 more, while i_addr_i changes after grant → mem_addr_o stays at the latched value and no timeout fires at 64.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Optional feature macro used by this slice: RR_FAIRNESS_EN (round-robin owner choice).
package mem_arb_pkg;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Which requester owns the current memory transaction.
  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Transaction FSM states, encoding fixed for legacy compatibility.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Width of the timeout counter; a disabled timeout (0) still gets one bit
  // so the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int timeout_cycles);
    if (timeout_cycles > 0) begin
      return $clog2(timeout_cycles + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational owner choice between fetch and data requests.
// RR_FAIRNESS_EN defined: on a conflict the requester not served last wins.
// RR_FAIRNESS_EN undefined: data always wins over fetch.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_owner_i,
  output logic   any_req_o,
  output owner_e owner_o
);

`ifdef RR_FAIRNESS_EN
  // Two-way round robin: a conflict goes to whoever was not served last.
  always_comb begin
    any_req_o = i_req_i | d_req_i;
    owner_o   = OWNER_I;
    if (i_req_i && d_req_i) begin
      if (last_owner_i == OWNER_D) begin
        owner_o = OWNER_I;
      end else begin
        owner_o = OWNER_D;
      end
    end else if (d_req_i) begin
      owner_o = OWNER_D;
    end else begin
      owner_o = OWNER_I;
    end
  end
`else
  // The last owner only matters for round robin; fixed priority ignores it.
  logic unused_last_owner_s;
  assign unused_last_owner_s = (last_owner_i == OWNER_D);

  // Fixed priority: data beats fetch whenever it is requesting.
  always_comb begin
    any_req_o = i_req_i | d_req_i;
    owner_o   = OWNER_I;
    if (d_req_i) begin
      owner_o = OWNER_D;
    end else begin
      owner_o = OWNER_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between instruction fetch and the data path,
// one outstanding transaction at a time, with a stall timeout that answers
// the owning requester with an error response.
// Optional feature macro: RR_FAIRNESS_EN (see mem_arb_select).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // fetch side
  input  logic             i_req_i,
  input  logic [WIDTH-1:0] i_addr_i,
  output logic             i_gnt_o,
  output logic             i_rvalid_o,
  output logic [WIDTH-1:0] i_rdata_o,
  output logic             i_err_o,
  // data side
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic             d_byte_op_i,
  input  logic [WIDTH-1:0] d_addr_i,
  input  logic [WIDTH-1:0] d_wdata_i,
  output logic             d_gnt_o,
  output logic             d_rvalid_o,
  output logic [WIDTH-1:0] d_rdata_o,
  output logic             d_err_o,
  // memory side
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_byte_op_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             busy_o
);

  localparam int                CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic             we_q, we_d, byte_op_q, byte_op_d;
  logic             mem_req_q, busy_q;
  logic             i_rvalid_q, i_err_q, d_rvalid_q, d_err_q;
  logic [WIDTH-1:0] i_rdata_q, d_rdata_q;

  logic             any_req_s, grant_s, timeout_s;
  logic             resp_fire_s, resp_err_s;
  logic [WIDTH-1:0] resp_data_s;
  owner_e           sel_owner_s, last_owner_s;

  // owner_q holds the most recent grant until the next one, so it doubles as
  // the round-robin history; without fairness the selector sees a constant.
`ifdef RR_FAIRNESS_EN
  assign last_owner_s = owner_q;
`else
  assign last_owner_s = OWNER_I;
`endif

  mem_arb_select u_select (
    .i_req_i      (i_req_i),
    .d_req_i      (d_req_i),
    .last_owner_i (last_owner_s),
    .any_req_o    (any_req_s),
    .owner_o      (sel_owner_s)
  );

  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
  assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Next-state logic: arbitration in IDLE, handshake progress and timeout
  // detection in REQ/WAIT, single-cycle response in RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    byte_op_d   = byte_op_q;
    grant_s     = 1'b0;
    resp_fire_s = 1'b0;
    resp_err_s  = 1'b0;
    resp_data_s = '0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          grant_s = 1'b1;
          owner_d = sel_owner_s;
          state_d = REQ;
          cnt_d   = '0;
          if (sel_owner_s == OWNER_D) begin
            addr_d    = d_addr_i;
            wdata_d   = d_wdata_i;
            we_d      = d_we_i;
            byte_op_d = d_byte_op_i;
          end else begin
            addr_d    = i_addr_i;
            wdata_d   = '0;
            we_d      = 1'b0;
            byte_op_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d = WAIT;
          cnt_d   = cnt_inc_s;
        end else if (timeout_s) begin
          state_d     = RESP;
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d     = RESP;
          resp_fire_s = 1'b1;
          resp_data_s = mem_rdata_i;
        end else if (timeout_s) begin
          state_d     = RESP;
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, owner, timeout counter and latched memory request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_I;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      byte_op_q <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      byte_op_q <= byte_op_d;
      mem_req_q <= (state_d == REQ);
      busy_q    <= (state_d != IDLE);
    end
  end

  // Response registers: a one-cycle rvalid pulse on the owner's side in RESP,
  // with data/err captured as the FSM leaves REQ/WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= resp_fire_s && (owner_q == OWNER_I);
      i_err_q    <= resp_fire_s && (owner_q == OWNER_I) && resp_err_s;
      d_rvalid_q <= resp_fire_s && (owner_q == OWNER_D);
      d_err_q    <= resp_fire_s && (owner_q == OWNER_D) && resp_err_s;
      if (resp_fire_s && (owner_q == OWNER_I)) begin
        i_rdata_q <= resp_data_s;
      end else begin
        i_rdata_q <= i_rdata_q;
      end
      if (resp_fire_s && (owner_q == OWNER_D)) begin
        d_rdata_q <= resp_data_s;
      end else begin
        d_rdata_q <= d_rdata_q;
      end
    end
  end

  // Grants are combinational so a requester sees acceptance in its request cycle.
  assign i_gnt_o       = grant_s && (sel_owner_s == OWNER_I);
  assign d_gnt_o       = grant_s && (sel_owner_s == OWNER_D);
  assign i_rvalid_o    = i_rvalid_q;
  assign i_err_o       = i_err_q;
  assign i_rdata_o     = i_rdata_q;
  assign d_rvalid_o    = d_rvalid_q;
  assign d_err_o       = d_err_q;
  assign d_rdata_o     = d_rdata_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = we_q;
  assign mem_byte_op_o = byte_op_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model: which side owns each transaction, what the memory must see, and when
// and on which side the response appears. Honours RR_FAIRNESS_EN if defined.
module tb_mem_port_arbiter;

  logic        clk, rst_ni;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_byte_op, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_byte_op, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  bit last_d;  // model history: 1 when data was served last

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_byte_op_i(d_byte_op),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_gnt_o(d_gnt),
    .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_byte_op_o(mem_byte_op),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the owner rule: 1 means the data side wins.
  function automatic bit pick(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef RR_FAIRNESS_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // One complete transaction; called at the drive point of an IDLE cycle and
  // returns at the drive point of the cycle after the response (IDLE again).
  // g/r: cycles (relative to the grant cycle) of mem_gnt_i and mem_rvalid_i.
  task automatic txn(input bit ir, input bit dr, input bit we, input bit bop,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int g, input int r, input bit keep, input bit inj);
    bit          own_d;
    logic [31:0] ea, ew;
    logic [1:0]  ectl;
    i_req = ir; d_req = dr; i_addr = ia;
    d_we = we; d_byte_op = bop; d_addr = da; d_wdata = wd;
    own_d = pick(ir, dr);
    if (own_d) begin
      ea = da; ew = wd; ectl = {we, bop};
    end else begin
      ea = ia; ew = 32'd0; ectl = 2'b00;
    end
    #4;
    chk("busy_at_grant", busy, 32'd0);
    chk("i_gnt", i_gnt, {31'd0, !own_d});
    chk("d_gnt", d_gnt, {31'd0, own_d});
    last_d = own_d;
    for (int c = 1; c <= r + 1; c++) begin
      step();
      if (own_d) d_req = 1'b0; else i_req = 1'b0;
      if (!keep) begin
        i_req = 1'b0; d_req = 1'b0;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom); d_byte_op = 1'($urandom);
      end
      mem_gnt    = (c == g);
      mem_rvalid = (c == r) || (inj && (c < g));
      mem_rdata  = (c == r) ? rd : $urandom;
      #4;
      chk("mem_req", mem_req, {31'd0, (c <= g)});
      if (c <= g) begin
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("mem_we_byte", {mem_we, mem_byte_op}, {30'd0, ectl});
      end
      chk("no_gnt_busy", {i_gnt, d_gnt}, 32'd0);
      chk("busy", busy, 32'd1);
      chk("i_rvalid", i_rvalid, {31'd0, (c == r + 1) && !own_d});
      chk("d_rvalid", d_rvalid, {31'd0, (c == r + 1) && own_d});
      if (c == r + 1) begin
        if (own_d) begin
          chk("d_rdata", d_rdata, rd);
          chk("d_err", d_err, 32'd0);
        end else begin
          chk("i_rdata", i_rdata, rd);
          chk("i_err", i_err, 32'd0);
        end
      end
    end
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    bit ir, dr;
    int g, r;
    rst_ni = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_byte_op = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    last_d = 1'b0;

    // Reset values
    #3;
    chk("rst_gnt_rvalid_err", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_mem_ctl", {mem_req, mem_we, mem_byte_op, busy}, 32'd0);
    chk("rst_mem_fields", mem_addr | mem_wdata, 32'd0);
    #4 rst_ni = 1'b1;
    step();

    // Fetch only, minimum latency
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0, 32'd0, 32'hDEADBEEF, 1, 2, 1'b0, 1'b0);

    // Both requesting for three transactions (D,D,D fixed; D,I,D round robin)
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000, 32'h0, 32'h11111111, 1, 2, 1'b1, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h2004, 32'h0, 32'h22222222, 2, 3, 1'b1, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h2008, 32'h0, 32'h33333333, 1, 3, 1'b0, 1'b0);

    // Byte store, fields held until the memory grant
    txn(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h104, 32'h000000AB, 32'h0, 3, 5, 1'b0, 1'b0);

    // Load leaving nonzero data in d_rdata before the timeout case
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h300, 32'd0, 32'hCAFE0001, 1, 2, 1'b0, 1'b0);

    // Memory never grants: 64 request cycles then an error response
    d_req = 1'b1; d_we = 1'b1; d_byte_op = 1'b0; d_addr = 32'h500; d_wdata = 32'h55;
    #4;
    chk("to_d_gnt", d_gnt, 32'd1);
    last_d = 1'b1;
    n = 0;
    do begin
      step();
      d_req = 1'b0;
      #4;
      if (mem_req === 1'b1) n++;
    end while (mem_req === 1'b1 && n < 200);
    chk("to_req_cycles", n, 32'd64);
    chk("to_d_rvalid", d_rvalid, 32'd1);
    chk("to_d_err", d_err, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    chk("to_i_rvalid", i_rvalid, 32'd0);
    step();
    #4;
    chk("to_busy_done", {busy, d_rvalid}, 32'd0);
    step();

    // Reset pulse while waiting for the response; late response ignored
    i_req = 1'b1; i_addr = 32'h80;
    #4;
    chk("rw_i_gnt", i_gnt, 32'd1);
    step();
    i_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rw_outputs", {busy, mem_req, i_rvalid, d_rvalid, i_err, d_err}, 32'd0);
    chk("rw_mem_addr", mem_addr, 32'd0);
    last_d = 1'b0;
    #2 rst_ni = 1'b1;
    step();
    #4;
    chk("rw_quiet1", {i_rvalid, d_rvalid, busy}, 32'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #4;
    chk("rw_quiet2", {i_rvalid, d_rvalid, busy}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    #4;
    chk("rw_quiet3", {i_rvalid, d_rvalid, busy, mem_req}, 32'd0);
    chk("rw_rdata", i_rdata, 32'd0);
    step();
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h84, 32'd0, 32'd0, 32'h0BADF00D, 2, 4, 1'b0, 1'b1);

    // Slow memory, requester address changes after grant
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'd0, 32'd0, 32'h600DCAFE, 5, 9, 1'b0, 1'b0);

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      ir = 1'($urandom);
      dr = 1'($urandom);
      if (!ir && !dr) dr = 1'b1;
      g = $urandom_range(1, 4);
      r = g + $urandom_range(1, 5);
      txn(ir, dr, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
          g, r, 1'b0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
